pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 123 ++++++++++++
 tb/tb_pc_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter control for the fetch stage.
// Tracks the fetch PC through a BOOT/RUN/HALT FSM and applies trap, mret,
// redirect, stall and sequential updates in fixed priority order. The PC
// advance count and the PC captured at the last trap are also kept here.
// Optional feature macro: PC_COMPRESSED_EN (16-bit instruction support:
// 2-byte increments and halfword-aligned redirect targets).
module pc_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_1000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic            mret,
  input  logic            halt,
  input  logic            resume,
  input  logic            inst_half,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic [31:0]     retired,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [31:0]     ret_q, ret_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] incr;
  logic            tgt_mis;

`ifdef PC_COMPRESSED_EN
  // 16-bit instructions advance by 2; only byte-odd targets are illegal
  assign incr    = inst_half ? XLEN'(2) : XLEN'(4);
  assign tgt_mis = redirect_target[0];
`else
  // Fixed 4-byte instructions; the half-size hint has no meaning here
  logic unused_inst_half;
  assign unused_inst_half = inst_half;
  assign incr    = XLEN'(4);
  assign tgt_mis = |redirect_target[1:0];
`endif

  // Sequential address wraps naturally modulo 2^XLEN
  assign pc_plus    = pc_q + incr;
  assign pc         = pc_q;
  assign epc        = epc_q;
  assign retired    = ret_q;
  assign misaligned = mis_q;
  assign state      = state_q;
  assign pc_valid   = (state_q == RUN);

  // State register; reset drops any update that was about to land
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      ret_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      ret_q   <= ret_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state and next-PC selection: trap > mret > bad redirect > redirect > stall > seq
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    ret_d   = ret_q;
    mis_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap) begin
          // A trap also cancels a same-cycle halt request
          pc_d  = TRAP_VECTOR;
          epc_d = pc_q;
        end else begin
          if (mret) begin
            pc_d  = epc_q;
            ret_d = ret_q + 32'd1;
          end else if (redirect_valid && !stall && tgt_mis) begin
            // Bad target is handled like a trap, flagged for one cycle
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
            mis_d = 1'b1;
          end else if (redirect_valid && !stall) begin
            pc_d  = redirect_target;
            ret_d = ret_q + 32'd1;
          end else if (!stall) begin
            pc_d  = pc_plus;
            ret_d = ret_q + 32'd1;
          end
          if (halt) state_d = HALT;
        end
      end
      HALT: begin
        if (resume && !halt) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed self-checking bench for pc_ctrl.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap = 1'b0;
  logic        mret = 1'b0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic        inst_half = 1'b0;
  logic [31:0] pc, pc_plus, epc, retired;
  logic        pc_valid, misaligned;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  pc_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap(trap), .mret(mret),
    .halt(halt), .resume(resume), .inst_half(inst_half),
    .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid), .epc(epc),
    .misaligned(misaligned), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  // One clock, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; redirect_valid = 0; redirect_target = '0; trap = 0;
    mret = 0; halt = 0; resume = 0; inst_half = 0;
  endtask

  // Reset then release mid-cycle; leaves the DUT in BOOT
  task automatic do_reset();
    clear_inputs();
    rst = 0;
    step(); step();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    step(); step();
    tests++; if (pc !== 32'h1000) begin fails++; $display("FAIL reset_pc got %h want %h", pc, 32'h1000); end
    tests++; if (epc !== 32'h0) begin fails++; $display("FAIL reset_epc got %h want 0", epc); end
    tests++; if (retired !== 32'h0) begin fails++; $display("FAIL reset_retired got %h want 0", retired); end
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL reset_mis got %b want 0", misaligned); end
    tests++; if (pc_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", pc_valid); end
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state got %b want 00", state); end
    rst = 1;
    #2;
    tests++; if (state !== 2'b00 || pc !== 32'h1000) begin fails++; $display("FAIL boot_hold state %b pc %h want 00 1000", state, pc); end
    step();
    tests++; if (state !== 2'b01 || pc !== 32'h1000 || pc_valid !== 1'b1 || retired !== 0) begin
      fails++; $display("FAIL boot_to_run state %b pc %h valid %b ret %0d want 01 1000 1 0", state, pc, pc_valid, retired); end
    step();
    tests++; if (pc !== 32'h1004 || retired !== 1) begin fails++; $display("FAIL seq1 pc %h ret %0d want 1004 1", pc, retired); end
    step();
    tests++; if (pc !== 32'h1008 || retired !== 2) begin fails++; $display("FAIL seq2 pc %h ret %0d want 1008 2", pc, retired); end
    tests++; if (pc_plus !== 32'h100C) begin fails++; $display("FAIL pc_plus got %h want 100c", pc_plus); end
  endtask

  // Continues from pc=1008h, retired=2
  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = (i == 1);
      redirect_target = 32'h2000;
      step();
      tests++; if (pc !== 32'h1008 || retired !== 2) begin fails++; $display("FAIL stall%0d pc %h ret %0d want 1008 2", i, pc, retired); end
    end
    clear_inputs();
  endtask

  // Continues from pc=1008h, retired=2
  task automatic test_redirect();
    redirect_valid = 1; redirect_target = 32'h2000;
    step();
    tests++; if (pc !== 32'h2000 || retired !== 3) begin fails++; $display("FAIL redir pc %h ret %0d want 2000 3", pc, retired); end
`ifdef PC_COMPRESSED_EN
    redirect_target = 32'h2002;
    step();
    tests++; if (pc !== 32'h2002 || misaligned !== 0 || retired !== 4) begin
      fails++; $display("FAIL redir_half pc %h mis %b ret %0d want 2002 0 4", pc, misaligned, retired); end
    redirect_target = 32'h2003;
    step();
    tests++; if (pc !== 32'h100 || epc !== 32'h2002 || misaligned !== 1 || retired !== 4) begin
      fails++; $display("FAIL redir_mis pc %h epc %h mis %b ret %0d want 100 2002 1 4", pc, epc, misaligned, retired); end
    clear_inputs();
    step();
    tests++; if (pc !== 32'h104 || misaligned !== 0 || retired !== 5) begin
      fails++; $display("FAIL mis_pulse pc %h mis %b ret %0d want 104 0 5", pc, misaligned, retired); end
`else
    redirect_target = 32'h2002;
    step();
    tests++; if (pc !== 32'h100 || epc !== 32'h2000 || misaligned !== 1 || retired !== 3) begin
      fails++; $display("FAIL redir_mis pc %h epc %h mis %b ret %0d want 100 2000 1 3", pc, epc, misaligned, retired); end
    clear_inputs();
    step();
    tests++; if (pc !== 32'h104 || misaligned !== 0 || retired !== 4) begin
      fails++; $display("FAIL mis_pulse pc %h mis %b ret %0d want 104 0 4", pc, misaligned, retired); end
`endif
  endtask

  task automatic test_trap();
    do_reset();
    step();                       // BOOT -> RUN at 1000h
    for (int i = 0; i < 4; i++) step();  // 1004,1008,100C,1010
    tests++; if (pc !== 32'h1010 || retired !== 4) begin fails++; $display("FAIL trap_setup pc %h ret %0d want 1010 4", pc, retired); end
    trap = 1; stall = 1; mret = 1;
    step();
    tests++; if (pc !== 32'h100 || epc !== 32'h1010 || retired !== 4) begin
      fails++; $display("FAIL trap pc %h epc %h ret %0d want 100 1010 4", pc, epc, retired); end
    clear_inputs();
    step();
    tests++; if (pc !== 32'h104 || retired !== 5) begin fails++; $display("FAIL post_trap pc %h ret %0d want 104 5", pc, retired); end
    mret = 1; stall = 1;
    step();
    tests++; if (pc !== 32'h1010 || epc !== 32'h1010 || retired !== 6) begin
      fails++; $display("FAIL mret pc %h epc %h ret %0d want 1010 1010 6", pc, epc, retired); end
    clear_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    step(); step();               // RUN, pc=1004h, retired=1
    halt = 1; stall = 1;
    step();
    tests++; if (state !== 2'b10 || pc !== 32'h1004 || pc_valid !== 0 || retired !== 1) begin
      fails++; $display("FAIL halt_enter state %b pc %h valid %b ret %0d want 10 1004 0 1", state, pc, pc_valid, retired); end
    clear_inputs(); trap = 1; redirect_valid = 1; redirect_target = 32'h3000;
    step();
    tests++; if (state !== 2'b10 || pc !== 32'h1004 || epc !== 0) begin
      fails++; $display("FAIL halt_ignore state %b pc %h epc %h want 10 1004 0", state, pc, epc); end
    clear_inputs(); halt = 1; resume = 1;
    step();
    tests++; if (state !== 2'b10) begin fails++; $display("FAIL halt_resume_both state %b want 10", state); end
    clear_inputs(); resume = 1;
    step();
    tests++; if (state !== 2'b01 || pc !== 32'h1004 || pc_valid !== 1) begin
      fails++; $display("FAIL resume state %b pc %h valid %b want 01 1004 1", state, pc, pc_valid); end
    clear_inputs();
    step();
    tests++; if (pc !== 32'h1008 || retired !== 2) begin fails++; $display("FAIL resume_adv pc %h ret %0d want 1008 2", pc, retired); end
    halt = 1;
    step();
    tests++; if (state !== 2'b10 || pc !== 32'h100C || retired !== 3) begin
      fails++; $display("FAIL halt_upd state %b pc %h ret %0d want 10 100c 3", state, pc, retired); end
    clear_inputs(); trap = 1;
    #2 rst = 0;
    #1;
    tests++; if (pc !== 32'h1000 || state !== 2'b00 || retired !== 0 || epc !== 0) begin
      fails++; $display("FAIL async_rst pc %h state %b ret %0d epc %h want 1000 00 0 0", pc, state, retired, epc); end
    step();
    tests++; if (pc !== 32'h1000 || state !== 2'b00) begin fails++; $display("FAIL rst_hold pc %h state %b want 1000 00", pc, state); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    step();
    tests++; if (pc !== 32'hFFFF_FFFC || pc_plus !== 32'h0 || retired !== 1) begin
      fails++; $display("FAIL wrap_redir pc %h plus %h ret %0d want fffffffc 0 1", pc, pc_plus, retired); end
    clear_inputs();
    step();
    tests++; if (pc !== 32'h0 || retired !== 2 || misaligned !== 0) begin
      fails++; $display("FAIL wrap_pc pc %h ret %0d mis %b want 0 2 0", pc, retired, misaligned); end
  endtask

  task automatic test_half();
    do_reset();
    step();
    inst_half = 1;
    step();
`ifdef PC_COMPRESSED_EN
    tests++; if (pc !== 32'h1002) begin fails++; $display("FAIL half_inc pc %h want 1002", pc); end
    inst_half = 0; redirect_valid = 1; redirect_target = 32'h1006;
    step();
    tests++; if (pc !== 32'h1006 || misaligned !== 0) begin fails++; $display("FAIL half_tgt pc %h mis %b want 1006 0", pc, misaligned); end
`else
    tests++; if (pc !== 32'h1004) begin fails++; $display("FAIL half_ignored pc %h want 1004", pc); end
`endif
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_trap();
    test_halt();
    test_wrap();
    test_half();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
